mii_rx_ctrl: RTL and testbench
==============================

Name: mii_rx_ctrl

Overview:
- Receive-frame sequencer behind the MII nibble-to-byte core, running in the same `mii_clk` domain.
- Consumes the core's byte strobe (`rdy`/`q`) plus `mii_en`, and tracks preamble and SFD.
- Extracts dst/src/type, applies a destination-MAC filter, then streams payload bytes with SOF/EOF/error framing.
- Maintains delivered/dropped frame counters.

Parameters:
- MIN_PRE, 6, minimum preamble bytes (0xAA) required before SFD.
- MAX_PAYLOAD, 1504, maximum post-header bytes (payload + FCS) before a frame is declared oversize.
- CNT_W, 16, width of the frame counters.

Ports:
- mii_clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_en  in  1  `mii_en` from the PHY; frame envelope.
- in_rdy  in  1  byte strobe from the MII core, high exactly one cycle per byte.
- in_q  in  8  byte from the MII core, valid when in_rdy=1.
- cfg_mac  in  48  station address; static while in_en=1.
- cfg_promisc  in  1  1 = accept any destination.
- hdr_valid  out  1  one-cycle pulse; header fields just updated.
- dst_mac  out  48  destination address of the last accepted frame.
- src_mac  out  48  source address of the last accepted frame.
- eth_type  out  16  type/length of the last accepted frame.
- out_valid  out  1  payload byte strobe.
- out_data  out  8  payload byte.
- out_sof  out  1  qualifies first payload byte.
- out_eof  out  1  qualifies last payload byte.
- out_err  out  1  qualifies the EOF byte of an oversize frame.
- frame_cnt  out  CNT_W  frames delivered with clean EOF.
- drop_cnt  out  CNT_W  frames rejected or errored.

Behaviour:
- Reset:
  - All outputs are 0, counters are 0, state is WAIT_IDLE, and the hold register is empty.
  - Reset mid-frame discards the frame and increments no counter.
- Byte order: header bytes are shifted in MSB-first. First header byte → dst_mac[47:40]; 6th → dst_mac[7:0]; bytes 7–12 → src_mac; 13–14 → eth_type.
- End-of-frame (EOF condition): in_en=0 with in_rdy=0. A strobe coincident with in_en=0 is accepted as data; end processing occurs the next cycle.
- States:
  - WAIT_IDLE: wait for in_en=0, then go to IDLE. This prevents joining a frame mid-stream after reset.
  - IDLE: in_en=1 → PRE, with pre_cnt=0.
  - PRE, per strobe:
    - 0xAA: pre_cnt++, saturating at 15.
    - 0xBA with pre_cnt≥MIN_PRE: go to HDR, byte_cnt=0.
    - 0xBA with pre_cnt<MIN_PRE, or any other byte: go to DROP, drop_cnt++.
    - EOF condition in PRE → IDLE with no count (carrier noise).
  - HDR:
    - Each strobe shifts into shadow registers; byte_cnt++.
    - After the 6th byte: accept if cfg_promisc, or dst==cfg_mac, or dst==48'hFFFF_FFFF_FFFF. Otherwise go to DROP, drop_cnt++.
    - After the 14th byte: copy shadows to dst_mac/src_mac/eth_type, pulse hdr_valid on the next cycle, go to PAY with pay_cnt=0.
    - EOF condition in HDR (runt): drop_cnt++, go to IDLE. Visible header outputs are unchanged.
  - PAY:
    - One-byte hold pipeline. Each strobe stores in_q in the hold register.
    - If the hold register was already full, the previous byte is emitted on the following cycle (out_valid=1), and out_sof=1 on the first emission only.
    - pay_cnt++ per strobe.
    - EOF condition with hold full: emit the held byte with out_eof=1 (plus out_sof=1 if it is the only byte), frame_cnt++, go to IDLE.
    - EOF condition with hold empty (zero payload bytes): no output, frame_cnt++, go to IDLE.
    - Strobe making pay_cnt = MAX_PAYLOAD+1: emit the held byte with out_eof=1 and out_err=1, drop_cnt++, go to DROP. The new byte is discarded.
  - DROP: ignore strobes; EOF condition → IDLE.
- Output protocol:
  - out_valid is high at most one cycle per input strobe, and never in two consecutive cycles unless the strobes are consecutive.
  - Latency is one cycle after the next strobe (or after the EOF condition).
- Counters saturate at all-ones and never wrap.
- FCS is passed through as the final 4 payload bytes and is not checked.

Test Plan:
- Nominal frame, cfg_mac=48'h54FF01212324, promisc=0:
  - Stimulus: 7×0xAA, 0xBA, then dst, src 48'h123456789ABC, type 16'h1234, 32 ASCII bytes "Twas' on the good ship Venus..." with NUL, 4 FCS bytes.
  - Response: hdr_valid pulses once with exact dst/src/type; 36 out_valid bytes in order; SOF on 'T'; EOF on the last FCS byte; frame_cnt=1, drop_cnt=0.
- Filter:
  - Same frame with cfg_mac=48'h000000000001 → no out_valid, no hdr_valid, drop_cnt=1.
  - Repeat with dst=FF..FF → delivered, frame_cnt=1.
  - Repeat with promisc=1 → delivered.
- Preamble errors:
  - 4×0xAA then 0xBA → DROP, drop_cnt=1, zero output.
  - 0xAA,0xAA,0x55 → DROP.
  - Next good frame is delivered normally.
- Runt: in_en falls after 9 header bytes → drop_cnt=1; dst_mac etc. retain the previous frame's values; no hdr_valid.
- Oversize, MAX_PAYLOAD=8: 12 payload bytes → 8 out_valid bytes, 8th with out_eof=1 and out_err=1; drop_cnt=1, frame_cnt=0; the following frame is delivered.
- Reset and edge cases:
  - Reset asserted mid-payload, released with in_en=1 → all outputs 0 and no output until in_en low then a fresh frame.
  - A 1-byte payload yields a single byte with out_sof=1 and out_eof=1.

Source files
------------

// File: rtl/mii_rx_ctrl.sv
// mii_rx_ctrl: receive-frame sequencer behind the MII nibble-to-byte core.
//
// It tracks the preamble and SFD, extracts the Ethernet header, applies a
// destination-MAC filter and streams the payload with SOF/EOF/error framing.
// It also keeps delivered and dropped frame counters.
//
// Ports (all in the mii_clk domain):
//   mii_clk      sole clock, rising edge
//   reset        synchronous, active-high
//   in_en        mii_en from the PHY; this is the frame envelope
//   in_rdy/in_q  byte strobe and byte from the MII core (one cycle per byte)
//   cfg_mac      station address, static while in_en=1
//   cfg_promisc  1 = accept any destination
//   hdr_valid    one-cycle pulse; dst_mac/src_mac/eth_type have just been updated
//   dst_mac, src_mac, eth_type  header of the last accepted frame
//   out_valid/out_data          payload byte strobe and byte
//   out_sof/out_eof/out_err     qualifiers of the out_valid byte
//   frame_cnt    frames delivered with a clean EOF (saturating)
//   drop_cnt     frames rejected or errored (saturating)
//
// Strobe semantics: out_valid is high for one cycle per emitted byte. There
// is no back-pressure, so the consumer must accept the byte in that cycle.
// out_sof, out_eof, out_err and out_data are meaningful only while out_valid=1.
// Outside that cycle they are driven to 0.
module mii_rx_ctrl #(
    parameter int MIN_PRE     = 6,
    parameter int MAX_PAYLOAD = 1504,
    parameter int CNT_W       = 16
) (
    input  logic             mii_clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic             in_rdy,
    input  logic [7:0]       in_q,
    input  logic [47:0]      cfg_mac,
    input  logic             cfg_promisc,
    output logic             hdr_valid,
    output logic [47:0]      dst_mac,
    output logic [47:0]      src_mac,
    output logic [15:0]      eth_type,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int PAY_W = $clog2(MAX_PAYLOAD + 2);
    localparam logic [3:0] MIN_PRE_C = 4'(MIN_PRE);
    localparam logic [PAY_W-1:0] PAY_MAX_C = PAY_W'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_PRE, S_HDR, S_PAY, S_DROP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [PAY_W-1:0] pay_cnt_q, pay_cnt_d;
    // First 13 header bytes; the 14th byte arrives on in_q when the header completes.
    logic [103:0]     shadow_q, shadow_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             first_q, first_d;      // no payload byte has been emitted yet
    logic [111:0]     hdr_q, hdr_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             eof_cond;
    logic [47:0]      dst_now;
    logic             dst_ok;
    logic             frame_inc;
    logic             drop_inc;

    // A strobe that coincides with in_en=0 is still data. End processing
    // happens only when neither the strobe nor the envelope is active.
    assign eof_cond = !in_en && !in_rdy;
    // The destination address is complete when the 6th header byte is on in_q.
    assign dst_now  = {shadow_q[39:0], in_q};
    assign dst_ok   = cfg_promisc || (dst_now == cfg_mac) || (&dst_now);

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        shadow_d    = shadow_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        first_d     = first_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_err_d   = 1'b0;
        frame_inc   = 1'b0;
        drop_inc    = 1'b0;

        case (state_q)
            S_WAIT_IDLE: begin
                if (!in_en) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (in_en) begin
                    state_d   = S_PRE;
                    pre_cnt_d = 4'd0;
                end
            end
            S_PRE: begin
                if (in_rdy) begin
                    if (in_q == 8'hAA) begin
                        if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                    end else if (in_q == 8'hBA && pre_cnt_q >= MIN_PRE_C) begin
                        state_d    = S_HDR;
                        byte_cnt_d = 4'd0;
                    end else begin
                        state_d  = S_DROP;
                        drop_inc = 1'b1;
                    end
                end else if (eof_cond) begin
                    // Carrier without a valid SFD is treated as noise and is not counted.
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (in_rdy) begin
                    shadow_d   = {shadow_q[95:0], in_q};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd5 && !dst_ok) begin
                        state_d  = S_DROP;
                        drop_inc = 1'b1;
                    end else if (byte_cnt_q == 4'd13) begin
                        hdr_d       = {shadow_q, in_q};
                        hdr_valid_d = 1'b1;
                        state_d     = S_PAY;
                        pay_cnt_d   = '0;
                        hold_full_d = 1'b0;
                        first_d     = 1'b1;
                    end
                end else if (eof_cond) begin
                    state_d  = S_IDLE;
                    drop_inc = 1'b1;
                end
            end
            S_PAY: begin
                if (in_rdy) begin
                    pay_cnt_d = pay_cnt_q + 1'b1;
                    if (pay_cnt_q == PAY_MAX_C) begin
                        // The frame is oversize. Close the stream on the held
                        // byte and discard the new byte.
                        out_valid_d = hold_full_q;
                        out_data_d  = hold_q;
                        out_sof_d   = hold_full_q && first_q;
                        out_eof_d   = hold_full_q;
                        out_err_d   = hold_full_q;
                        hold_full_d = 1'b0;
                        state_d     = S_DROP;
                        drop_inc    = 1'b1;
                    end else begin
                        if (hold_full_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_q;
                            out_sof_d   = first_q;
                            first_d     = 1'b0;
                        end
                        hold_d      = in_q;
                        hold_full_d = 1'b1;
                    end
                end else if (eof_cond) begin
                    out_valid_d = hold_full_q;
                    out_data_d  = hold_full_q ? hold_q : 8'h00;
                    out_sof_d   = hold_full_q && first_q;
                    out_eof_d   = hold_full_q;
                    hold_full_d = 1'b0;
                    frame_inc   = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_DROP: begin
                if (eof_cond) state_d = S_IDLE;
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (frame_inc && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            state_q     <= S_WAIT_IDLE;
            pre_cnt_q   <= 4'd0;
            byte_cnt_q  <= 4'd0;
            pay_cnt_q   <= '0;
            shadow_q    <= '0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            first_q     <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            shadow_q    <= shadow_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_err_q   <= out_err_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign hdr_valid = hdr_valid_q;
    assign dst_mac   = hdr_q[111:64];
    assign src_mac   = hdr_q[63:16];
    assign eth_type  = hdr_q[15:0];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_err   = out_err_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_mii_rx_ctrl.sv
// Bench for mii_rx_ctrl. Two instances share the same inputs: u0 uses the
// default MAX_PAYLOAD and u1 uses MAX_PAYLOAD=8, which exercises the oversize case.
module tb_mii_rx_ctrl;
    localparam int MIN_PRE = 6;
    localparam int MAXP0   = 1504;
    localparam int MAXP1   = 8;
    localparam logic [47:0] MAC_A = 48'h54FF01212324;
    localparam logic [47:0] SRC_A = 48'h123456789ABC;

    logic        mii_clk = 1'b0;
    logic        reset, in_en, in_rdy, cfg_promisc;
    logic [7:0]  in_q;
    logic [47:0] cfg_mac;

    logic        hv0, ov0, os0, oe0, oerr0, hv1, ov1, os1, oe1, oerr1;
    logic [47:0] dst0, src0, dst1, src1;
    logic [15:0] typ0, typ1, fc0, dc0, fc1, dc1;
    logic [7:0]  od0, od1;

    int tests = 0;
    int fails = 0;

    // Expected stream entries are {err, eof, sof, data}.
    logic [10:0]  exp_q0[$];
    logic [10:0]  exp_q1[$];
    logic [111:0] hexp_q0[$];
    logic [111:0] hexp_q1[$];
    logic [7:0]   tx_q[$];
    int           mod_frame[2];
    int           mod_drop[2];
    logic [111:0] mod_hdr[2];
    int           mon_cnt[2];
    logic [10:0]  mon_first[2];
    logic [10:0]  mon_last[2];

    // ---------------- clock / reset ----------------
    always #5 mii_clk = ~mii_clk;

    mii_rx_ctrl #(.MIN_PRE(MIN_PRE), .MAX_PAYLOAD(MAXP0), .CNT_W(16)) u0 (
        .mii_clk(mii_clk), .reset(reset), .in_en(in_en), .in_rdy(in_rdy), .in_q(in_q),
        .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc), .hdr_valid(hv0), .dst_mac(dst0),
        .src_mac(src0), .eth_type(typ0), .out_valid(ov0), .out_data(od0), .out_sof(os0),
        .out_eof(oe0), .out_err(oerr0), .frame_cnt(fc0), .drop_cnt(dc0));

    mii_rx_ctrl #(.MIN_PRE(MIN_PRE), .MAX_PAYLOAD(MAXP1), .CNT_W(16)) u1 (
        .mii_clk(mii_clk), .reset(reset), .in_en(in_en), .in_rdy(in_rdy), .in_q(in_q),
        .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc), .hdr_valid(hv1), .dst_mac(dst1),
        .src_mac(src1), .eth_type(typ1), .out_valid(ov1), .out_data(od1), .out_sof(os1),
        .out_eof(oe1), .out_err(oerr1), .frame_cnt(fc1), .drop_cnt(dc1));

    task automatic tick();
        @(posedge mii_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [111:0] got, input logic [111:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    // The model derives the frame outcome directly from the byte list: the
    // preamble length, the SFD, the header bytes, the filter and the payload length.
    task automatic bump(input int inst, input bit delivered);
        if (delivered) begin
            if (mod_frame[inst] != 16'hFFFF) mod_frame[inst]++;
        end else begin
            if (mod_drop[inst] != 16'hFFFF) mod_drop[inst]++;
        end
    endtask

    task automatic push_exp(input int inst, input logic [10:0] e);
        if (inst == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic model_frame(input int inst, input int maxp);
        int n, i, pre, pay;
        logic [47:0]  d;
        logic [111:0] h;
        n = tx_q.size();
        i = 0;
        pre = 0;
        while (i < n && tx_q[i] == 8'hAA) begin
            pre++;
            i++;
        end
        if (i == n) return;
        if (tx_q[i] != 8'hBA || pre < MIN_PRE) begin
            bump(inst, 0);
            return;
        end
        i++;
        if (n - i >= 6) begin
            d = '0;
            for (int k = 0; k < 6; k++) d = {d[39:0], tx_q[i+k]};
            if (!(cfg_promisc || d == cfg_mac || d == 48'hFFFF_FFFF_FFFF)) begin
                bump(inst, 0);
                return;
            end
        end
        if (n - i < 14) begin
            bump(inst, 0);
            return;
        end
        h = '0;
        for (int k = 0; k < 14; k++) h = {h[103:0], tx_q[i+k]};
        if (inst == 0) hexp_q0.push_back(h);
        else hexp_q1.push_back(h);
        mod_hdr[inst] = h;
        i = i + 14;
        pay = n - i;
        if (pay > maxp) begin
            for (int k = 0; k < maxp; k++)
                push_exp(inst, {k == maxp - 1, k == maxp - 1, k == 0, tx_q[i+k]});
            bump(inst, 0);
        end else begin
            for (int k = 0; k < pay; k++)
                push_exp(inst, {1'b0, k == pay - 1, k == 0, tx_q[i+k]});
            bump(inst, 1);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    task automatic mon_out(input int inst, input logic v, input logic sof, input logic eof,
                           input logic err, input logic [7:0] d, input logic hv,
                           input logic [111:0] hdr);
        logic [10:0]  got, e;
        logic [111:0] he;
        got = {err, eof, sof, d};
        if (v) begin
            if ((inst == 0 && exp_q0.size() == 0) || (inst == 1 && exp_q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL out%0d_unexpected got=%0h exp=none", inst, got);
            end else begin
                if (inst == 0) e = exp_q0.pop_front();
                else e = exp_q1.pop_front();
                check($sformatf("out%0d_byte", inst), 112'(got), 112'(e));
            end
            mon_cnt[inst]++;
            if (mon_cnt[inst] == 1) mon_first[inst] = got;
            mon_last[inst] = got;
        end else begin
            check($sformatf("out%0d_qual_idle", inst), {109'd0, sof, eof, err}, 112'd0);
        end
        if (hv) begin
            if ((inst == 0 && hexp_q0.size() == 0) || (inst == 1 && hexp_q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL hdr%0d_unexpected got=%0h exp=none", inst, hdr);
            end else begin
                if (inst == 0) he = hexp_q0.pop_front();
                else he = hexp_q1.pop_front();
                check($sformatf("hdr%0d_fields", inst), hdr, he);
            end
        end
    endtask

    always @(negedge mii_clk) begin
        mon_out(0, ov0, os0, oe0, oerr0, od0, hv0, {dst0, src0, typ0});
        mon_out(1, ov1, os1, oe1, oerr1, od1, hv1, {dst1, src1, typ1});
    end

    // ---------------- driver ----------------
    task automatic new_frame(input int npre, input logic [7:0] sfd);
        tx_q.delete();
        repeat (npre) tx_q.push_back(8'hAA);
        tx_q.push_back(sfd);
    endtask

    task automatic add_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        for (int k = 5; k >= 0; k--) tx_q.push_back(d[k*8 +: 8]);
        for (int k = 5; k >= 0; k--) tx_q.push_back(s[k*8 +: 8]);
        tx_q.push_back(t[15:8]);
        tx_q.push_back(t[7:0]);
    endtask

    task automatic add_nominal_payload();
        string s;
        s = "Twas' on the good ship Venus...";
        for (int k = 0; k < s.len(); k++) tx_q.push_back(s[k]);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hDE);
        tx_q.push_back(8'hAD);
        tx_q.push_back(8'hBE);
        tx_q.push_back(8'hEF);
    endtask

    task automatic add_pattern(input int n);
        for (int k = 0; k < n; k++) tx_q.push_back(8'(k * 7 + 3));
    endtask

    // Each byte is strobed for one cycle and followed by one gap cycle. When
    // drop_en is set, in_en falls during the gap after the last byte.
    task automatic strobe_bytes(input bit drop_en);
        for (int k = 0; k < tx_q.size(); k++) begin
            in_rdy = 1'b1;
            in_q   = tx_q[k];
            tick();
            in_rdy = 1'b0;
            in_q   = 8'h00;
            if (drop_en && k == tx_q.size() - 1) in_en = 1'b0;
            tick();
        end
    endtask

    task automatic end_check();
        check("q0_drained", 112'(exp_q0.size() + hexp_q0.size()), 112'd0);
        check("q1_drained", 112'(exp_q1.size() + hexp_q1.size()), 112'd0);
        check("frame_cnt0", 112'(fc0), 112'(mod_frame[0]));
        check("drop_cnt0", 112'(dc0), 112'(mod_drop[0]));
        check("frame_cnt1", 112'(fc1), 112'(mod_frame[1]));
        check("drop_cnt1", 112'(dc1), 112'(mod_drop[1]));
        check("hdr0_hold", {dst0, src0, typ0}, mod_hdr[0]);
        check("hdr1_hold", {dst1, src1, typ1}, mod_hdr[1]);
    endtask

    task automatic run_frame();
        model_frame(0, MAXP0);
        model_frame(1, MAXP1);
        mon_cnt[0] = 0;
        mon_cnt[1] = 0;
        in_en = 1'b1;
        tick();
        tick();
        strobe_bytes(1'b1);
        repeat (6) tick();
        end_check();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mod_frame[k] = 0;
            mod_drop[k]  = 0;
            mod_hdr[k]   = '0;
        end
    endtask

    // ---------------- directed sequence ----------------
    int d0, f0;

    initial begin
        reset = 1'b1;
        in_en = 1'b0;
        in_rdy = 1'b0;
        in_q = 8'h00;
        cfg_mac = MAC_A;
        cfg_promisc = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_outputs", {dst0, src0, typ0}, 112'd0);
        check("rst_strobes", {107'd0, hv0, ov0, os0, oe0, oerr0}, 112'd0);
        check("rst_counters", {80'd0, fc0, dc0}, 112'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Nominal frame
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h1234);
        add_nominal_payload();
        run_frame();
        check("nom_frame_cnt", 112'(fc0), 112'd1);
        check("nom_drop_cnt", 112'(dc0), 112'd0);
        check("nom_bytes", 112'(mon_cnt[0]), 112'd36);
        check("nom_first_sof_T", 112'(mon_first[0]), 112'h154);
        check("nom_last_eof", 112'(mon_last[0]), 112'h2EF);
        check("nom_hdr", {dst0, src0, typ0}, {MAC_A, SRC_A, 16'h1234});
        check("ovs_nom_bytes", 112'(mon_cnt[1]), 112'd8);
        check("ovs_nom_last", 112'(mon_last[1]), 112'h66E);
        check("ovs_nom_cnts", {80'd0, fc1, dc1}, {80'd0, 16'd0, 16'd1});

        // Destination filter
        cfg_mac = 48'h000000000001;
        d0 = dc0;
        run_frame();
        check("filt_drop", 112'(dc0 - 16'(d0)), 112'd1);
        check("filt_no_bytes", 112'(mon_cnt[0]), 112'd0);
        f0 = fc0;
        new_frame(7, 8'hBA);
        add_hdr(48'hFFFF_FFFF_FFFF, SRC_A, 16'h0800);
        add_nominal_payload();
        run_frame();
        check("bcast_frame", 112'(fc0 - 16'(f0)), 112'd1);
        cfg_promisc = 1'b1;
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h86DD);
        add_pattern(20);
        run_frame();
        check("promisc_bytes", 112'(mon_cnt[0]), 112'd20);
        cfg_promisc = 1'b0;
        cfg_mac = MAC_A;

        // Preamble errors
        d0 = dc0;
        new_frame(4, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h1234);
        add_pattern(5);
        run_frame();
        new_frame(2, 8'h55);
        run_frame();
        check("pre_err_drops", 112'(dc0 - 16'(d0)), 112'd2);
        new_frame(6, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h0101);
        add_pattern(3);
        run_frame();
        check("pre_ok_bytes", 112'(mon_cnt[0]), 112'd3);

        // Runt: 9 header bytes then carrier loss
        d0 = dc0;
        new_frame(7, 8'hBA);
        add_pattern(0);
        for (int k = 5; k >= 0; k--) tx_q.push_back(MAC_A[k*8 +: 8]);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        run_frame();
        check("runt_drop", 112'(dc0 - 16'(d0)), 112'd1);
        check("runt_hdr_kept", {dst0, src0, typ0}, {MAC_A, SRC_A, 16'h0101});

        // Oversize on u1: 12 payload bytes
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h0042);
        add_pattern(12);
        run_frame();
        check("ovs_bytes", 112'(mon_cnt[1]), 112'd8);
        check("ovs_last_err", 112'(mon_last[1]), 112'h634);
        check("ovs_big_bytes", 112'(mon_cnt[0]), 112'd12);

        // 1-byte and 0-byte payloads
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h0001);
        add_pattern(1);
        run_frame();
        check("one_byte_cnt", 112'(mon_cnt[0]), 112'd1);
        check("one_byte_sof_eof", 112'(mon_first[0]), 112'h303);
        f0 = fc0;
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h0000);
        run_frame();
        check("zero_pay_frame", 112'(fc0 - 16'(f0)), 112'd1);
        check("zero_pay_bytes", 112'(mon_cnt[0]), 112'd0);

        // Reset mid-payload, released with in_en high
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h0777);
        add_pattern(5);
        hexp_q0.push_back({MAC_A, SRC_A, 16'h0777});
        hexp_q1.push_back({MAC_A, SRC_A, 16'h0777});
        for (int k = 0; k < 4; k++) begin
            push_exp(0, {2'b00, k == 0, 8'(k * 7 + 3)});
            push_exp(1, {2'b00, k == 0, 8'(k * 7 + 3)});
        end
        in_en = 1'b1;
        tick();
        tick();
        strobe_bytes(1'b0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        tick();
        check("mrst_outputs", {dst0, src0, typ0}, 112'd0);
        check("mrst_counters", {64'd0, fc0, dc0, fc1, dc1}, 112'd0);
        check("mrst_drained", 112'(exp_q0.size() + exp_q1.size()), 112'd0);
        // A complete frame while the envelope is still high must be ignored.
        mon_cnt[0] = 0;
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h1234);
        add_pattern(4);
        strobe_bytes(1'b1);
        repeat (4) tick();
        check("mrst_no_join", {64'd0, 16'(mon_cnt[0]), fc0, dc0}, 112'd0);
        end_check();

        // A fresh frame after the reset recovery
        new_frame(7, 8'hBA);
        add_hdr(MAC_A, SRC_A, 16'h1234);
        add_nominal_payload();
        run_frame();
        check("post_rst_frame", 112'(fc0), 112'd1);
        check("post_rst_bytes", 112'(mon_cnt[0]), 112'd36);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL timeout got=running exp=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
